// File: rtl/lt24_pkg.sv
// Shared LT24 definitions: default panel geometry, RGB565 width and the
// frame-streamer FSM state encoding.
package lt24_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;
  localparam int RGB565_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_PREFETCH  = 3'd2,
    ST_LOAD      = 3'd3,
    ST_SEND_A    = 3'd4,
    ST_SEND_B    = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/lt24_pixel_counter.sv
// Linear pixel index with terminal-count flag for the LT24 frame streamer.
module lt24_pixel_counter #(
  parameter int ADDR_W   = 17,
  parameter int LAST_IDX = 76799
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(LAST_IDX);
  localparam logic [ADDR_W-1:0] ONE_C  = ADDR_W'(1);

  // Index register: clear has priority over increment, both gated by en.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {ADDR_W{1'b0}};
    end else if (en && clr) begin
      count <= {ADDR_W{1'b0}};
    end else if (en && inc) begin
      count <= count + ONE_C;
    end
  end

  assign last = (count == LAST_C);

endmodule

// File: rtl/lt24_frame_streamer.sv
// Streams one RGB565 framebuffer (row-major) to the LT24 LCD driver, one pixel
// per two enabled cycles. Define LT24_STREAMER_CONTINUOUS_EN for back-to-back frames.
module lt24_frame_streamer
  import lt24_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                initialized,
  input  logic                start,
  output logic [ADDR_W-1:0]   fb_addr,
  input  logic [RGB565_W-1:0] fb_rdata,
  output logic [RGB565_W-1:0] pixel_rgb,
  output logic                print,
  output logic                busy,
  output logic                frame_done
);

  localparam int              NPIX   = H_RES * V_RES;
  localparam logic [ADDR_W:0] LAST_X = (ADDR_W + 1)'(NPIX - 1);
  localparam logic [ADDR_W:0] ONE_X  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] TWO_X  = (ADDR_W + 1)'(2);

  state_t            state_r;
  logic [ADDR_W-1:0] count_s;
  logic              last_s;
  logic              clr_s;
  logic              inc_s;
  logic              start_s;
  logic [ADDR_W-1:0] addr_a_s;
  logic [ADDR_W-1:0] addr_b_s;

  // Prefetch addresses saturate at the last pixel so fb_addr never leaves the frame.
  function automatic logic [ADDR_W-1:0] cap_addr(input logic [ADDR_W:0] a);
    logic [ADDR_W-1:0] r;
    if (a > LAST_X) begin
      r = LAST_X[ADDR_W-1:0];
    end else begin
      r = a[ADDR_W-1:0];
    end
    return r;
  endfunction

`ifdef LT24_STREAMER_CONTINUOUS_EN
  logic unused_start_s;
  assign unused_start_s = start;
  assign start_s        = 1'b1;
`else
  assign start_s = start;
`endif

  assign clr_s    = (state_r == ST_PREFETCH);
  assign inc_s    = (state_r == ST_SEND_B) && initialized && !last_s;
  assign addr_a_s = cap_addr({1'b0, count_s} + ONE_X);
  assign addr_b_s = cap_addr({1'b0, count_s} + TWO_X);

  lt24_pixel_counter #(
    .ADDR_W   (ADDR_W),
    .LAST_IDX (NPIX - 1)
  ) u_pixel_counter (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr_s),
    .inc   (inc_s),
    .count (count_s),
    .last  (last_s)
  );

  // Frame sequencer; every output is a register updated only on enabled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      fb_addr    <= {ADDR_W{1'b0}};
      pixel_rgb  <= {RGB565_W{1'b0}};
      print      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (en) begin
      case (state_r)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (start_s) begin
            busy    <= 1'b1;
            state_r <= ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (initialized) begin
            fb_addr <= {ADDR_W{1'b0}};
            state_r <= ST_PREFETCH;
          end
        end
        ST_PREFETCH: begin
          fb_addr <= {ADDR_W{1'b0}};
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          pixel_rgb <= fb_rdata;
          fb_addr   <= addr_a_s;
          print     <= 1'b1;
          state_r   <= ST_SEND_A;
        end
        ST_SEND_A: begin
          if (!initialized) begin
            print   <= 1'b0;
            state_r <= ST_WAIT_INIT;
          end else begin
            state_r <= ST_SEND_B;
          end
        end
        // fb_rdata here already holds the next pixel, prefetched during SEND_A.
        ST_SEND_B: begin
          if (!initialized) begin
            print   <= 1'b0;
            state_r <= ST_WAIT_INIT;
          end else if (last_s) begin
            print      <= 1'b0;
            frame_done <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            pixel_rgb <= fb_rdata;
            fb_addr   <= addr_b_s;
            state_r   <= ST_SEND_A;
          end
        end
        ST_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          print      <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
